obs_destutter: RTL

- Downstream consumer of the source/target code-block stages in the compiler-optimization case studies.
- Samples the registered observation pair (a, b) and the stutter flag each cycle, discards stutter cycles and repeated values, and buffers the resulting destuttered observation trace in a small FIFO for a valid/ready consumer.
- Also reports when the observed trace has settled, i.e. the computation has reached its terminal step.

---
 rtl/obs_destutter_if.sv | 43 ++++
 rtl/obs_destutter.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/obs_destutter_if.sv
// -----------------------------------------------------------------------------
// obs_destutter_if
// Bundles the observation inputs and the consumer-side FIFO outputs of
// obs_destutter.
//   slave  : the destutter block (samples a/b/stutter and obs_ready, drives the
//            FIFO head, occupancy and status flags)
//   master : the surrounding logic (upstream code block and consumer)
// Optional macro OBS_DESTUTTER_STUTTER_CNT_EN adds the stutter_cnt signal.
// -----------------------------------------------------------------------------
interface obs_destutter_if #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 4
);
  logic                     a_in;
  logic                     b_in;
  logic                     stutter_in;
  logic                     obs_ready;
  logic                     obs_valid;
  logic                     obs_a;
  logic                     obs_b;
  logic [$clog2(DEPTH):0]   fill;
  logic                     overflow;
  logic                     settled;
`ifdef OBS_DESTUTTER_STUTTER_CNT_EN
  logic [CNT_W-1:0]         stutter_cnt;
`endif

  modport slave (
    input  a_in, b_in, stutter_in, obs_ready,
    output obs_valid, obs_a, obs_b, fill, overflow, settled
`ifdef OBS_DESTUTTER_STUTTER_CNT_EN
    , output stutter_cnt
`endif
  );

  modport master (
    output a_in, b_in, stutter_in, obs_ready,
    input  obs_valid, obs_a, obs_b, fill, overflow, settled
`ifdef OBS_DESTUTTER_STUTTER_CNT_EN
    , input stutter_cnt
`endif
  );
endinterface

// File: rtl/obs_destutter.sv
// -----------------------------------------------------------------------------
// obs_destutter
// Samples the upstream observation pair (a, b) every cycle, ignores cycles
// flagged as stutter and samples equal to the previous one, and queues the
// resulting destuttered trace in a small show-ahead FIFO for a valid/ready
// consumer. It also flags when the trace has been unchanged for SETTLE
// consecutive samples (the computation reached its terminal step).
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   bus       obs_destutter_if.slave:
//               a_in, b_in, stutter_in  observation inputs
//               obs_ready               consumer takes the head entry
//               obs_valid, obs_a, obs_b FIFO head (show-ahead)
//               fill                    FIFO occupancy 0..DEPTH
//               overflow                sticky, a push was dropped
//               settled                 trace stable for >= SETTLE samples
//               stutter_cnt             (optional) stutter cycles since push
//
// Optional feature macro: OBS_DESTUTTER_STUTTER_CNT_EN
// -----------------------------------------------------------------------------
module obs_destutter #(
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 4,
  parameter int SETTLE = 3
) (
  input  logic            clk,
  input  logic            rst,
  obs_destutter_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = AW + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  logic [1:0]       mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [FW-1:0]    fill_q;
  logic [1:0]       head_q;
  logic [1:0]       last_q;
  logic             seen_q;
  logic [CNT_W-1:0] cnt_q;
  logic             settled_q;
  logic             overflow_q;

  logic [1:0]       cur;
  logic             sample;
  logic             push;
  logic             pop;
  logic             full;
  logic             push_ok;
  logic [FW-1:0]    fill_nxt;
  logic [FW-1:0]    remain;
  logic [AW-1:0]    rd_nxt;
  logic [1:0]       head_nxt;
  logic [CNT_W-1:0] cnt_inc;

  assign cur     = {bus.a_in, bus.b_in};
  assign sample  = !bus.stutter_in;
  // First sample always goes in; afterwards only changes are recorded.
  assign push    = sample && (!seen_q || (cur != last_q));
  assign pop     = bus.obs_valid && bus.obs_ready;
  assign full    = (fill_q == FW'(DEPTH));
  // A pop in the same cycle frees the slot the push needs.
  assign push_ok = push && (!full || pop);
  assign cnt_inc = sat_inc(cnt_q);

  always_comb begin
    fill_nxt = fill_q;
    if (push_ok && !pop)
      fill_nxt = fill_q + 1'b1;
    else if (!push_ok && pop)
      fill_nxt = fill_q - 1'b1;

    rd_nxt = pop ? rd_ptr + 1'b1 : rd_ptr;
    remain = pop ? fill_q - 1'b1 : fill_q;

    // Head is registered so it holds its last value once the FIFO drains.
    // When nothing older survives this edge, the new head is the value
    // being pushed right now (it is not in mem yet).
    head_nxt = head_q;
    if (fill_nxt != '0)
      head_nxt = (remain == '0) ? cur : mem[rd_nxt];
  end

  // Storage array: data only, no reset.
  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr] <= cur;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_q     <= '0;
      head_q     <= '0;
      last_q     <= '0;
      seen_q     <= 1'b0;
      cnt_q      <= '0;
      settled_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      fill_q <= fill_nxt;
      rd_ptr <= rd_nxt;
      head_q <= head_nxt;
      if (push_ok)
        wr_ptr <= wr_ptr + 1'b1;
      if (push && !push_ok)
        overflow_q <= 1'b1;

      // Stutter cycles leave last, counter and settled untouched.
      // last follows every change, even one dropped on overflow.
      if (sample) begin
        if (!seen_q) begin
          last_q <= cur;
          seen_q <= 1'b1;
          cnt_q  <= '0;
        end else if (cur != last_q) begin
          last_q    <= cur;
          cnt_q     <= '0;
          settled_q <= 1'b0;
        end else begin
          cnt_q <= cnt_inc;
          if (cnt_inc >= CNT_W'(SETTLE))
            settled_q <= 1'b1;
        end
      end
    end
  end

`ifdef OBS_DESTUTTER_STUTTER_CNT_EN
  logic [CNT_W-1:0] stut_q;

  always_ff @(posedge clk) begin
    if (rst)
      stut_q <= '0;
    else if (push_ok)
      stut_q <= '0;
    else if (bus.stutter_in)
      stut_q <= sat_inc(stut_q);
  end

  assign bus.stutter_cnt = stut_q;
`endif

  assign bus.obs_valid = (fill_q != '0);
  assign bus.obs_a     = head_q[1];
  assign bus.obs_b     = head_q[0];
  assign bus.fill      = fill_q;
  assign bus.overflow  = overflow_q;
  assign bus.settled   = settled_q;

endmodule
